// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage: stall-vector and
//   IC->ID bus widths, stall encodings, the FSM state type, the slot entry
//   record and a helper that packs a slot entry onto the IC->ID bus.
//   Optional build macro used by this slice: FETCH_SKID_EN (see fetch_slot).
package fetch_stage_pkg;

  localparam int STALL_BUS_W = 6;
  localparam int IC_TO_ID_WD = 65;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int          EXC_ADEL_BIT     = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_CANCEL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] exc;
    logic [31:0] inst;
    logic [31:0] pc;
  } slot_entry_t;

  // Empty slot presents an all-zero bubble to decode.
  function automatic logic [IC_TO_ID_WD-1:0] pack_ic_bus(input logic valid,
                                                         input slot_entry_t e);
    return valid ? {e.exc, 1'b1, e.pc} : '0;
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// fetch_slot
//   Output buffer between fetch and decode. Holds one entry (head); with
//   FETCH_SKID_EN defined it holds a second skid entry behind the head so a
//   response can land while decode is stalled.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   clear           drop every entry (flush)
//   consume         decode takes the head entry this cycle (if valid)
//   trim            branch redirect: keep only the oldest surviving entry,
//                   accept no new one
//   fill/fill_entry write a new entry
//   head_valid/head_entry  entry presented to decode
//   can_accept      room exists for a fill this cycle
//   keep_avail      an entry survives this cycle's consume (delay slot held)
module fetch_slot
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        consume,
  input  logic        trim,
  input  logic        fill,
  input  slot_entry_t fill_entry,
  output logic        head_valid,
  output slot_entry_t head_entry,
  output logic        can_accept,
  output logic        keep_avail
);

  logic        head_valid_reg, head_valid_next;
  slot_entry_t head_reg, head_next;
  logic        fill_ok;

  // A redirect that keeps the current entry never takes a new one.
  assign fill_ok = fill && !trim;

`ifdef FETCH_SKID_EN
  logic        skid_valid_reg, skid_valid_next;
  slot_entry_t skid_reg, skid_next;

  always_comb begin
    head_valid_next = head_valid_reg;
    head_next       = head_reg;
    skid_valid_next = skid_valid_reg;
    skid_next       = skid_reg;
    // Consume shifts the skid entry forward into the head.
    if (consume && head_valid_reg) begin
      head_valid_next = skid_valid_reg;
      head_next       = skid_reg;
      skid_valid_next = 1'b0;
    end
    if (trim) begin
      skid_valid_next = 1'b0;
    end
    if (fill_ok) begin
      if (!head_valid_next) begin
        head_valid_next = 1'b1;
        head_next       = fill_entry;
      end else begin
        skid_valid_next = 1'b1;
        skid_next       = fill_entry;
      end
    end
    if (clear) begin
      head_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end
  end

  assign can_accept = !skid_valid_reg || consume;
  assign keep_avail = skid_valid_reg || (head_valid_reg && !consume);

  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_valid_reg <= 1'b0;
      skid_reg       <= '0;
    end else begin
      skid_valid_reg <= skid_valid_next;
      skid_reg       <= skid_next;
    end
  end
`else
  always_comb begin
    head_valid_next = head_valid_reg;
    head_next       = head_reg;
    if (consume) begin
      head_valid_next = 1'b0;
    end
    if (fill_ok) begin
      head_valid_next = 1'b1;
      head_next       = fill_entry;
    end
    if (clear) begin
      head_valid_next = 1'b0;
    end
  end

  assign can_accept = !head_valid_reg || consume;
  assign keep_avail = head_valid_reg && !consume;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_valid_reg <= 1'b0;
      head_reg       <= '0;
    end else begin
      head_valid_reg <= head_valid_next;
      head_reg       <= head_next;
    end
  end

  assign head_valid = head_valid_reg;
  assign head_entry = head_reg;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: owns the PC, runs a one-outstanding SRAM-like
//   request to instruction memory and hands fetched words to decode through
//   fetch_slot. Handles flush redirects and branch redirects with MIPS
//   delay-slot semantics. Build macro FETCH_SKID_EN adds a skid entry.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   stall[5:0]               stall[1] stops this stage, stall[2] stops decode
//   flush, new_pc            exception/eret redirect
//   br_e, br_addr            taken branch from decode
//   stallreq                 stage waiting on memory
//   inst_req, inst_addr      request to instruction memory
//   inst_addr_ok             request accepted
//   inst_data_ok, inst_rdata response
//   ic_to_id_bus             {excepttype[31:0], ic_ce, ic_pc[31:0]}
//   ic_inst                  instruction word for decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADEL_BIT = EXC_ADEL_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_BUS_W-1:0] stall,
  input  logic                   flush,
  input  logic [31:0]            new_pc,
  input  logic                   br_e,
  input  logic [31:0]            br_addr,
  output logic                   stallreq,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [31:0]            inst_rdata,
  output logic [IC_TO_ID_WD-1:0] ic_to_id_bus,
  output logic [31:0]            ic_inst
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  br_tgt_reg, br_tgt_next;
  logic         br_pend_reg, br_pend_next;

  logic         consume, can_accept, keep_avail, head_valid;
  slot_entry_t  head_entry, fill_entry;
  logic         fill, clear, trim;
  logic         misaligned, run_ok, accepted, br_keep, redirect;
  logic [31:0]  pc_seq;
  logic [31:0]  adel_exc;
  logic         unused_stall_bits;

  assign unused_stall_bits = ^{stall[STALL_BUS_W-1:3], stall[0]};

  assign adel_exc   = 32'd1 << ADEL_BIT;
  assign consume    = (stall[2] == NO_STOP);
  assign misaligned = (pc_reg[1:0] != 2'b00);
  assign run_ok     = rst && (state_reg == ST_RUN) && can_accept && (stall[1] == NO_STOP);
  assign inst_req   = run_ok && !misaligned;
  assign inst_addr  = pc_reg;
  assign accepted   = inst_req && inst_addr_ok;
  // Branch while the delay slot is already buffered: redirect right away.
  assign br_keep    = br_e && keep_avail;
  assign redirect   = flush || br_keep;
  assign pc_seq     = br_pend_reg ? br_tgt_reg : pc_reg + 32'd4;

  assign stallreq = ((state_reg == ST_RUN) && inst_req && !inst_addr_ok)
                 || ((state_reg == ST_WAIT) && !inst_data_ok)
                 || (state_reg == ST_CANCEL);

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    br_tgt_next  = br_tgt_reg;
    br_pend_next = br_pend_reg;
    fill         = 1'b0;
    fill_entry   = '0;
    clear        = 1'b0;
    trim         = 1'b0;

    if (redirect) begin
      clear        = flush;
      trim         = !flush;
      pc_next      = flush ? new_pc : br_addr;
      br_pend_next = 1'b0;
      // Anything in flight now belongs to the wrong path.
      case (state_reg)
        ST_RUN:    if (accepted) state_next = ST_CANCEL;
        ST_WAIT,
        ST_CANCEL: state_next = inst_data_ok ? ST_RUN : ST_CANCEL;
        default:   state_next = ST_RUN;
      endcase
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (accepted) begin
            state_next = ST_WAIT;
          end else if (run_ok && misaligned) begin
            fill           = 1'b1;
            fill_entry.pc  = pc_reg;
            fill_entry.exc = adel_exc;
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            fill            = 1'b1;
            fill_entry.pc   = pc_reg;
            fill_entry.inst = inst_rdata;
            state_next      = ST_RUN;
          end
        end
        ST_CANCEL: if (inst_data_ok) state_next = ST_RUN;
        default:   state_next = ST_RUN;
      endcase

      // A fill completing alongside a branch is that branch's delay slot.
      if (fill) begin
        pc_next      = br_e ? br_addr : pc_seq;
        br_pend_next = 1'b0;
      end else if (br_e) begin
        br_tgt_next  = br_addr;
        br_pend_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_RUN;
      pc_reg      <= RESET_PC;
      br_tgt_reg  <= '0;
      br_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      br_tgt_reg  <= br_tgt_next;
      br_pend_reg <= br_pend_next;
    end
  end

  fetch_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .consume    (consume),
    .trim       (trim),
    .fill       (fill),
    .fill_entry (fill_entry),
    .head_valid (head_valid),
    .head_entry (head_entry),
    .can_accept (can_accept),
    .keep_avail (keep_avail)
  );

  assign ic_to_id_bus = pack_ic_bus(head_valid, head_entry);
  assign ic_inst      = head_valid ? head_entry.inst : ZERO_WORD;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_e;
  logic [31:0] br_addr;
  logic        stallreq;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [64:0] ic_to_id_bus;
  logic [31:0] ic_inst;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  int sc0 = 0;
  int mem_delay = 0;
  int mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] req_log[$];
  logic [96:0] sb[$];
  logic [96:0] mon_exp;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .br_e         (br_e),
    .br_addr      (br_addr),
    .stallreq     (stallreq),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .ic_to_id_bus (ic_to_id_bus),
    .ic_inst      (ic_inst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [96:0] exp_entry(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic [31:0] exc);
    return {exc, 1'b1, pc, inst};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: accepts when idle, answers after mem_delay wait cycles.
  assign inst_addr_ok = inst_req & ~mem_busy;
  assign inst_data_ok = mem_busy && (mem_cnt == 0);
  assign inst_rdata   = mem_word(mem_addr);

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
    end else if (mem_busy && inst_data_ok) begin
      mem_busy <= 1'b0;
    end else if (inst_req && inst_addr_ok) begin
      mem_busy <= 1'b1;
      mem_cnt  <= mem_delay;
      mem_addr <= inst_addr;
      req_log.push_back(inst_addr);
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  // Scoreboard: every entry decode takes is popped and compared.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (stallreq) stall_cnt++;
      if (ic_to_id_bus[32] && stall[2] == 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_delivery", {ic_to_id_bus, ic_inst}, 128'h0);
        end else begin
          mon_exp = sb.pop_front();
          chk("deliver", {ic_to_id_bus, ic_inst}, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reqs(input int n);
    int k = 0;
    while (req_log.size() < n && k < 60) begin
      step();
      k++;
    end
    chk("req_count", req_log.size(), n);
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int k = 0;
    while (!(req_log.size() > 0 && req_log[$] == a) && k < 60) begin
      step();
      k++;
    end
    chk("req_addr", (req_log.size() > 0) ? req_log[$] : 32'h0, a);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      step();
      k++;
    end
    chk("drained", sb.size(), 0);
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush  = 1'b1;
    new_pc = pc;
    step();
    flush  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
    br_e = 1'b0; br_addr = 32'h0; mem_delay = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_bus", ic_to_id_bus, 0);
    chk("rst_inst", ic_inst, 0);
    chk("rst_inst_req", inst_req, 0);
    chk("rst_stallreq", stallreq, 0);

    // 1: zero-wait stream from the reset vector
    sb.push_back(exp_entry(32'hBFC0_0000, mem_word(32'hBFC0_0000), 32'h0));
    sb.push_back(exp_entry(32'hBFC0_0004, mem_word(32'hBFC0_0004), 32'h0));
    sb.push_back(exp_entry(32'hBFC0_0008, mem_word(32'hBFC0_0008), 32'h0));
    step();
    rst = 1'b1;
    sc0 = stall_cnt;
    wait_reqs(3);
    stall = 6'b000010;
    drain();
    chk("t1_addr0", req_log[0], 32'hBFC0_0000);
    chk("t1_addr1", req_log[1], 32'hBFC0_0004);
    chk("t1_addr2", req_log[2], 32'hBFC0_0008);
    chk("t1_stallreq_cycles", stall_cnt - sc0, 0);
    req_log.delete();

    // 2: three wait cycles before data_ok
    mem_delay = 3;
    sb.push_back(exp_entry(32'hBFC0_000C, mem_word(32'hBFC0_000C), 32'h0));
    stall = 6'b0;
    sc0 = stall_cnt;
    wait_reqs(1);
    stall = 6'b000010;
    repeat (3) step();
    @(negedge clk);
    chk("t2_data_ok", inst_data_ok, 1);
    chk("t2_ce_at_data_ok", ic_to_id_bus[32], 0);
    step();
    @(negedge clk);
    chk("t2_ce_after", ic_to_id_bus[32], 1);
    drain();
    chk("t2_stallreq_cycles", stall_cnt - sc0, 3);
    chk("t2_addr", req_log[0], 32'hBFC0_000C);
    req_log.delete();

    // 3: flush while waiting on memory
    mem_delay = 2;
    sb.push_back(exp_entry(32'hBFC0_0380, mem_word(32'hBFC0_0380), 32'h0));
    stall = 6'b0;
    wait_reqs(1);
    flush = 1'b1;
    new_pc = 32'hBFC0_0380;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t3_cancel_stallreq", stallreq, 1);
    chk("t3_cancel_ce", ic_to_id_bus[32], 0);
    step();
    @(negedge clk);
    chk("t3_dropped_data_ok", inst_data_ok, 1);
    chk("t3_dropped_ce", ic_to_id_bus[32], 0);
    wait_reqs(2);
    stall = 6'b000010;
    chk("t3_redirect_addr", req_log[1], 32'hBFC0_0380);
    drain();
    mem_delay = 0;
    req_log.delete();

    // 4a: branch with the delay slot already in the slot
    do_flush(32'hBFC0_0008);
    sb.push_back(exp_entry(32'hBFC0_0008, mem_word(32'hBFC0_0008), 32'h0));
    sb.push_back(exp_entry(32'h8000_1000, mem_word(32'h8000_1000), 32'h0));
    stall = 6'b000100;
    wait_reqs(1);
    stall = 6'b000110;
    step();
    step();
    @(negedge clk);
    chk("t4a_slot_pc", ic_to_id_bus[32:0], {1'b1, 32'hBFC0_0008});
    step();
    br_e = 1'b1;
    br_addr = 32'h8000_1000;
    stall = 6'b000100;
    step();
    br_e = 1'b0;
    stall = 6'b0;
    wait_addr(32'h8000_1000);
    stall = 6'b000010;
    drain();
`ifdef FETCH_SKID_EN
    chk("t4a_req_count", req_log.size(), 3);
`else
    chk("t4a_req_count", req_log.size(), 2);
`endif
    req_log.delete();

    // 4b: branch with the delay slot still in flight
    do_flush(32'hBFC0_0008);
    mem_delay = 2;
    sb.push_back(exp_entry(32'hBFC0_0008, mem_word(32'hBFC0_0008), 32'h0));
    sb.push_back(exp_entry(32'h8000_1000, mem_word(32'h8000_1000), 32'h0));
    stall = 6'b0;
    wait_reqs(1);
    br_e = 1'b1;
    br_addr = 32'h8000_1000;
    step();
    br_e = 1'b0;
    wait_addr(32'h8000_1000);
    stall = 6'b000010;
    chk("t4b_req_count", req_log.size(), 2);
    chk("t4b_first_addr", req_log[0], 32'hBFC0_0008);
    drain();
    mem_delay = 0;
    req_log.delete();

    // 5: misaligned fetch address
    do_flush(32'hBFC0_0002);
    sb.push_back(exp_entry(32'hBFC0_0002, 32'h0, 32'h0001_0000));
    stall = 6'b0;
    @(negedge clk);
    chk("t5_no_inst_req", inst_req, 0);
    step();
    stall = 6'b000010;
    drain();
    chk("t5_req_count", req_log.size(), 0);

    // 6: decode stalled with the slot full
    do_flush(32'hBFC0_0100);
    sb.push_back(exp_entry(32'hBFC0_0100, mem_word(32'hBFC0_0100), 32'h0));
`ifdef FETCH_SKID_EN
    sb.push_back(exp_entry(32'hBFC0_0104, mem_word(32'hBFC0_0104), 32'h0));
`endif
    stall = 6'b000100;
    wait_reqs(1);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_bus_stable", ic_to_id_bus, {32'h0, 1'b1, 32'hBFC0_0100});
      chk("t6_inst_stable", ic_inst, mem_word(32'hBFC0_0100));
`ifndef FETCH_SKID_EN
      chk("t6_no_inst_req", inst_req, 0);
`endif
      step();
    end
`ifdef FETCH_SKID_EN
    chk("t6_req_count", req_log.size(), 2);
`else
    chk("t6_req_count", req_log.size(), 1);
`endif
    stall = 6'b000010;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
